// File: rtl/gfx_pkg.sv
// Shared graphics definitions for the drawing path: canvas geometry, palette
// width, the transparent colour index, sprite IDs and the blitter state type.
package gfx_pkg;

  localparam int CANVAS_W = 320;
  localparam int CANVAS_H = 240;
  localparam int PIX_DW   = 8;

  localparam logic [PIX_DW-1:0] TRANSPARENT_IDX = 8'h00;

  typedef enum logic [1:0] {
    DOODLE_L = 2'd0,
    DOODLE_R = 2'd1,
    PLATFORM = 2'd2,
    SPRING   = 2'd3
  } sprite_id_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } blit_state_t;

endpackage

// File: rtl/sprite_blitter.sv
// Streams one sprite from an external synchronous ROM into the framebuffer
// write port, skipping transparent pixels and clipping to the canvas.
module sprite_blitter
  import gfx_pkg::*;
#(
  parameter int              W           = CANVAS_W,
  parameter int              H           = CANVAS_H,
  parameter int              DW          = PIX_DW,
  parameter int              SPR_W       = 16,
  parameter int              SPR_H       = 16,
  parameter int              NUM_SPR     = 4,
  parameter logic [DW-1:0]   TRANSPARENT = TRANSPARENT_IDX
) (
  input  logic                                        Clk,
  input  logic                                        Reset,
  input  logic                                        start,
  input  logic [$clog2(NUM_SPR)-1:0]                  spr_id,
  input  logic [9:0]                                  pos_x,
  input  logic [9:0]                                  pos_y,
  input  logic                                        flip_x,
  input  logic                                        hold,
  output logic                                        rom_rd,
  output logic [$clog2(NUM_SPR*SPR_W*SPR_H)-1:0]      rom_addr,
  input  logic [DW-1:0]                               rom_data,
  output logic [9:0]                                  draw_x,
  output logic [9:0]                                  draw_y,
  output logic [DW-1:0]                               draw_color,
  output logic                                        wr_en,
  output logic                                        busy,
  output logic                                        done
);

  localparam int IDW = $clog2(NUM_SPR);
  localparam int SXW = $clog2(SPR_W);
  localparam int SYW = $clog2(SPR_H);

  localparam logic [SXW-1:0] SX_LAST = SXW'(SPR_W - 1);
  localparam logic [SYW-1:0] SY_LAST = SYW'(SPR_H - 1);

  blit_state_t    state_q, state_d;
  logic [IDW-1:0] spr_q, spr_d;
  logic [9:0]     pos_x_q, pos_x_d;
  logic [9:0]     pos_y_q, pos_y_d;
  logic           flip_q, flip_d;
  logic [SXW-1:0] sx_q, sx_d;
  logic [SYW-1:0] sy_q, sy_d;
  logic           drain_q, drain_d;

  // Stage 1 travels alongside the ROM read; stage 2 is the output register.
  logic           s1_valid_q;
  logic [SXW-1:0] s1_sx_q;
  logic [SYW-1:0] s1_sy_q;
  logic           qual_q;
  logic [9:0]     draw_x_q;
  logic [9:0]     draw_y_q;
  logic [DW-1:0]  color_q;

  logic [SXW-1:0] sx_src;
  logic [10:0]    tx;
  logic [10:0]    ty;
  logic           qual_d;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      spr_q   <= '0;
      pos_x_q <= '0;
      pos_y_q <= '0;
      flip_q  <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      drain_q <= 1'b0;
    end else begin
      // NOTE: registers take <= so every flop samples pre-edge values together.
      state_q <= state_d;
      spr_q   <= spr_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      flip_q  <= flip_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments keep this block from inferring latches.
    state_d = state_q;
    spr_d   = spr_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    flip_d  = flip_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    drain_d = drain_q;

    if (!hold) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            spr_d   = spr_id;
            pos_x_d = pos_x;
            pos_y_d = pos_y;
            flip_d  = flip_x;
            sx_d    = '0;
            sy_d    = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (sx_q == SX_LAST) begin
            sx_d = '0;
            if (sy_q == SY_LAST) begin
              drain_d = 1'b0;
              state_d = DRAIN;
            end else begin
              sy_d = sy_q + SYW'(1);
            end
          end else begin
            sx_d = sx_q + SXW'(1);
          end
        end
        DRAIN: begin
          if (drain_q) state_d = DONE;
          drain_d = 1'b1;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign sx_src   = flip_q ? (SX_LAST - sx_q) : sx_q;
  assign rom_addr = {spr_q, sy_q, sx_src};
  assign rom_rd   = (state_q == RUN) && !hold;

  // Target coordinates are one bit wider than the ports so off-canvas
  // positions near the 10-bit limit cannot wrap back onto the canvas.
  assign tx     = {1'b0, pos_x_q} + 11'(s1_sx_q);
  assign ty     = {1'b0, pos_y_q} + 11'(s1_sy_q);
  assign qual_d = s1_valid_q && (tx < 11'(W)) && (ty < 11'(H)) &&
                  (rom_data != TRANSPARENT);

  // NOTE: the pipeline has a small fixed set of flops, so all of them are
  // reset; this is what makes every output read 0 right after reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      s1_valid_q <= 1'b0;
      s1_sx_q    <= '0;
      s1_sy_q    <= '0;
      qual_q     <= 1'b0;
      draw_x_q   <= '0;
      draw_y_q   <= '0;
      color_q    <= '0;
    end else if (!hold) begin
      s1_valid_q <= (state_q == RUN);
      s1_sx_q    <= sx_q;
      s1_sy_q    <= sy_q;
      qual_q     <= qual_d;
      draw_x_q   <= tx[9:0];
      draw_y_q   <= ty[9:0];
      color_q    <= rom_data;
    end
  end

  assign draw_x     = draw_x_q;
  assign draw_y     = draw_y_q;
  assign draw_color = color_q;
  assign wr_en      = qual_q && !hold;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE) && !hold;

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Pixel writer for the Doodle Jump drawing path. On a `start` request it reads one 16×16 sprite from an external synchronous sprite ROM. It streams the sprite's opaque pixels into the framebuffer write port as `draw_x`/`draw_y`/`draw_color` with a `wr_en` strobe, and clips anything outside the W×H canvas. It is the producer end of the framebuffer pixel interface, sitting between the drawing engine (which issues blit requests) and the framebuffer.

## Interface
Parameters:
- `W`, 320, canvas width in pixels
- `H`, 240, canvas height in pixels
- `DW`, 8, palette-index color width
- `SPR_W`, 16, sprite width (power of 2)
- `SPR_H`, 16, sprite height (power of 2)
- `NUM_SPR`, 4, sprites stored in ROM (power of 2)
- `TRANSPARENT`, 8'h00, color index that is never written

Ports (one clock; reset is synchronous and active-low):
- `Clk`  in  1  system clock, 50 MHz
- `Reset`  in  1  synchronous, active-low reset
- `start`  in  1  blit request, sampled only in IDLE
- `spr_id`  in  log2(NUM_SPR)  sprite index, latched on accepted start
- `pos_x`  in  10  top-left X, unsigned, latched on start
- `pos_y`  in  10  top-left Y, unsigned, latched on start
- `flip_x`  in  1  mirror horizontally, latched on start
- `hold`  in  1  stall; freezes the whole pipeline
- `rom_rd`  out  1  ROM read enable
- `rom_addr`  out  log2(NUM_SPR·SPR_W·SPR_H)  {spr_id, sy, sx_src}
- `rom_data`  in  DW  ROM output, valid one cycle after `rom_rd`; ROM holds it while `rom_rd`=0
- `draw_x`  out  10  framebuffer X
- `draw_y`  out  10  framebuffer Y
- `draw_color`  out  DW  palette index
- `wr_en`  out  1  framebuffer write strobe
- `busy`  out  1  blit in progress
- `done`  out  1  one-cycle pulse at blit completion

## Operation
- FSM states:
  - IDLE: `start`=1 latches spr_id/pos/flip, clears sx, sy, and goes to RUN.
  - RUN: one pixel per non-held cycle; sx increments, and wraps to 0 with sy+1. After sx=SPR_W-1, sy=SPR_H-1 it goes to DRAIN.
  - DRAIN: 2 non-held cycles to flush the pipeline, then DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `start` is ignored outside IDLE.
- `rom_rd` = (state==RUN) & ~hold.
- `sx_src` = flip ? SPR_W-1-sx : sx.
- Pipeline has 2 stages:
  - Stage 1 registers valid, sx, sy alongside the ROM read.
  - Stage 2 registers `draw_x`/`draw_y`/`draw_color` and the write qualifier.
- Target coordinates: tx = pos_x+sx and ty = pos_y+sy, computed 11 bits wide. A write is qualified when valid & tx<W & ty<H & rom_data≠TRANSPARENT. `draw_x`/`draw_y` carry the low 10 bits.
- `wr_en` = qualifier_q & ~hold. Output registers keep their values while `hold`=1.
- `busy` = state∈{RUN, DRAIN}.
- Reset (Reset=0 at an edge), including mid-blit: state→IDLE, pipeline valids cleared. All outputs read 0 in the next cycle.

## Timing
- `start` is sampled at the edge ending cycle 0. Sx=0/sy=0 is presented in cycle 1.
- With hold=0, the first `wr_en` can assert in cycle 3, and pixel n is written in cycle n+3.
- The last pixel is written in cycle 258.
- `busy` is high in cycles 1–258. `done` is high in cycle 259, with `busy`=0.
- A new `start` is accepted in cycle 260 at the earliest.
- Blit length is fixed at SPR_W·SPR_H+3 cycles, independent of clipping and transparency.
- Each cycle with hold=1 delays every later event by exactly one cycle and emits no `wr_en`.

## Structure
- Shared `gfx_pkg` holds:
  - canvas W/H
  - DW
  - the TRANSPARENT index
  - the sprite-ID enum (DOODLE_L, DOODLE_R, PLATFORM, SPRING)
  - the `blit_state_t` enum {IDLE, RUN, DRAIN, DONE}
- No sub-module is needed. The sprite ROM is external so the drawing engine and the blitter can share it through the top level.

## Test plan
- Opaque sprite 0 (ROM word = addr[7:0]|1), start at (10,20):
  - 256 writes, the first (10,20) in cycle 3 and the last (25,35) in cycle 258
  - done in cycle 259
- Start at (310,230): exactly 100 writes, covering x 310–319 and y 230–239. No write has tx≥320 or ty≥240. Done still in cycle 259.
- Sprite 1 checkerboard with 0x00: exactly 128 writes, none carrying color 0x00.
- flip_x=1 at (0,0): the first write is (0,0) with the ROM word at sx_src=15, sy=0.
- hold=1 for 5 cycles starting cycle 50:
  - no `wr_en` during hold
  - the pixel sequence is identical to the unheld run
  - done in cycle 264
- Hold test continued: a second `start` pulsed in cycle 100 is ignored, so exactly one done is seen.
- Reset=0 in cycle 120: `busy`, `wr_en` and `done` are 0 from cycle 121. A start in cycle 123 begins a fresh blit.
